pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline stage register, the next generation of the ID/EX-style stage latch. It carries a data payload and a control bundle between two pipeline stages with a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and hazard-unit `stall` and `flush` inputs. The block drops in at any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) of the processor.

## Interface
Parameters:
- `DATA_W`, default 160: payload width (operands, immediate, instruction, register addresses packed by the instantiating stage).
- `CTRL_W`, default 10: control bundle width (RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, ALUOp, RegWrite).
- `BUBBLE_CTRL`, default 0: value driven on `out_ctrl` for an empty or flushed slot (a NOP bubble).

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: upstream presents a valid entry.
- `in_ready` output 1: the stage can accept an entry this cycle.
- `in_data` input DATA_W: payload in.
- `in_ctrl` input CTRL_W: control in.
- `out_valid` output 1: the head entry is valid for downstream.
- `out_ready` input 1: downstream consumes the head entry this cycle.
- `out_data` output DATA_W: head payload.
- `out_ctrl` output CTRL_W: head control, or `BUBBLE_CTRL` when `out_valid` is 0.
- `stall` input 1: hazard-unit hold; freezes the stage.
- `flush` input 1: hazard-unit kill; discards all held entries.
- `occupancy` output 2: number of held entries (0, 1 or 2).

## Operation
- Storage:
  - Main register: `main_valid`, `main_data`, `main_ctrl`; drives the outputs.
  - Skid register: `skid_valid`, `skid_data`, `skid_ctrl`.
- Handshake terms:
  - `accept` = `in_valid` && `in_ready`.
  - `pop` = `out_valid` && `out_ready`.
- Combinational outputs:
  - `in_ready` = !`skid_valid` && !`stall`.
  - `out_valid` = `main_valid` && !`stall`.
  - `out_data` = `main_data`.
  - `out_ctrl` = `main_valid` ? `main_ctrl` : `BUBBLE_CTRL`.
  - `occupancy` = `main_valid` + `skid_valid`.
- States are encoded by the (`main_valid`, `skid_valid`) pair. Transitions:
  - EMPTY (0,0): accept → ONE, main ← in.
  - ONE (1,0): accept & pop → ONE, main ← in. accept & !pop → FULL, skid ← in. !accept & pop → EMPTY. Neither → ONE, unchanged.
  - FULL (1,1): `in_ready`=0. pop → ONE, main ← skid, skid cleared. Otherwise hold.
  - (0,1) is illegal and must never be reached.
- Entries leave in strict FIFO order; none is duplicated or dropped except by `flush`.
- `stall`=1: no accept, no pop, all registers hold. Upstream and downstream see the stage as blocked.
- `flush`=1 (priority over `stall` and over any accept or pop):
  - `main_valid` and `skid_valid` are cleared and `main_ctrl` is set to `BUBBLE_CTRL` at the edge.
  - An entry presented with `in_valid` in the flush cycle is discarded, even though `in_ready` may read 1.
  - Data registers are left unchanged.

## Timing
- Reset values:
  - `main_valid`=0, `skid_valid`=0, all data registers 0, `main_ctrl`=`BUBBLE_CTRL`, skid control 0.
  - Resulting outputs: `out_valid`=0, `in_ready`=1 (when `stall`=0), `out_ctrl`=`BUBBLE_CTRL`, `out_data`=0, `occupancy`=0.
  - Counters (if present) are 0.
- Latency: an entry accepted at edge N is on `out_*` with `out_valid`=1 after edge N, i.e. one cycle.
- Throughput: one entry per cycle sustained while `out_ready`=1.
- Backpressure: `in_ready` falls the cycle after a skid capture. It rises the cycle after a pop from FULL.
- `stall` and `flush` act combinationally on the handshake and take effect at the next edge.
- Reset asserted mid-transfer clears all state immediately, with no clock required. The first accept after reset deassertion is on the first rising edge where `in_valid`=1.

## Configuration
- `PIPE_STAGE_PERF_EN` defined adds three 32-bit saturating counter outputs, each cleared by `reset`:
  - `perf_stall_cycles`: +1 every edge with `stall`=1.
  - `perf_bubble_cycles`: +1 every edge with `out_ready`=1 and `out_valid`=0.
  - `perf_flush_count`: +1 every edge with `flush`=1.
  - Each counter saturates at 0xFFFF_FFFF.
- Undefined: these ports and counters do not exist, and the datapath behaviour is identical.

## Test plan
- Reset then stream: `out_ready`=1, accept data 1,2,3 on consecutive cycles → `out_data` 1,2,3 one cycle later each, `occupancy` stays 1, `in_ready` stays 1.
- Backpressure: `out_ready`=0, push A, B → `occupancy`=2, `in_ready`=0. Push C is held off. Raise `out_ready` → A, B, C delivered in order, `in_ready` returns to 1 one cycle after the first pop.
- Stall: `occupancy`=1 with entry X, `stall`=1 for 3 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=0, state unchanged. Release → X popped, then the new entry.
- Flush with FULL and simultaneous `in_valid`, `stall`=1 → next cycle `occupancy`=0, `out_ctrl`=`BUBBLE_CTRL`, and the input entry never appears.
- Async reset asserted mid-cycle while FULL → `out_valid`=0 and `occupancy`=0 before the next clock edge.
- With `PIPE_STAGE_PERF_EN`: 4 stall cycles, 2 flushes, 3 idle `out_ready` cycles → counters read 4, 3, 2 (stall, bubble, flush).

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake, 2-entry skid buffer, stall/flush.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
   parameter int                  DATA_W      = 160,
   parameter int                  CTRL_W      = 10,
   parameter logic [CTRL_W-1:0]   BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              stall,
   input  logic              flush,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_bubble_cycles,
   output logic [31:0]       perf_flush_count
`endif
);

   // State bits are {main_valid, skid_valid}; 2'b01 is unreachable.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              main_valid;
   logic              skid_valid;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   logic              accept;
   logic              pop;
   logic              take;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid;

   assign main_valid = state[1];
   assign skid_valid = state[0];

   // Handshake terms; a flush discards whatever would have been accepted.
   always_comb begin
      accept = in_valid && in_ready;
      pop    = out_valid && out_ready;
      take   = accept && !flush;
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (take) begin
                  state_next = ST_ONE;
               end else begin
                  state_next = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (take && !pop) begin
                  state_next = ST_FULL;
               end else if (!take && pop) begin
                  state_next = ST_EMPTY;
               end else begin
                  state_next = ST_ONE;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  state_next = ST_ONE;
               end else begin
                  state_next = ST_FULL;
               end
            end
            default: begin
               state_next = ST_EMPTY;
            end
         endcase
      end
   end

   // Output and datapath-steering logic
   always_comb begin
      in_ready       = !skid_valid && !stall;
      out_valid      = main_valid && !stall;
      out_data       = main_data;
      out_ctrl       = main_valid ? main_ctrl : BUBBLE_CTRL;
      occupancy      = {1'b0, main_valid} + {1'b0, skid_valid};
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               load_main_in = take;
            end
            ST_ONE: begin
               load_main_in = take && pop;
               load_skid    = take && !pop;
            end
            ST_FULL: begin
               load_main_skid = pop;
            end
            default: begin
               load_main_in = 1'b0;
            end
         endcase
      end
   end

   // Main register: fed from the input or from the skid entry; flush only bubbles the control.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_data <= {DATA_W{1'b0}};
         main_ctrl <= BUBBLE_CTRL;
      end else if (flush) begin
         main_data <= main_data;
         main_ctrl <= BUBBLE_CTRL;
      end else if (load_main_in) begin
         main_data <= in_data;
         main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
         main_data <= skid_data;
         main_ctrl <= skid_ctrl;
      end else begin
         main_data <= main_data;
         main_ctrl <= main_ctrl;
      end
   end

   // Skid register: captures the input when the main slot is blocked
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_data <= {DATA_W{1'b0}};
         skid_ctrl <= {CTRL_W{1'b0}};
      end else if (load_skid) begin
         skid_data <= in_data;
         skid_ctrl <= in_ctrl;
      end else begin
         skid_data <= skid_data;
         skid_ctrl <= skid_ctrl;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic hit);
      if (hit && (value != CNT_MAX)) begin
         sat_inc = value + 32'd1;
      end else begin
         sat_inc = value;
      end
   endfunction

   // Saturating hazard/idle counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cycles  <= 32'd0;
         perf_bubble_cycles <= 32'd0;
         perf_flush_count   <= 32'd0;
      end else begin
         perf_stall_cycles  <= sat_inc(perf_stall_cycles, stall);
         perf_bubble_cycles <= sat_inc(perf_bubble_cycles, out_ready && !out_valid);
         perf_flush_count   <= sat_inc(perf_flush_count, flush);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (stream, backpressure, stall, flush, async reset).
module tb_pipe_stage_reg;

   localparam int          DW  = 32;
   localparam int          CW  = 10;
   localparam logic [9:0]  BUB = 10'h155;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic          stall;
   logic          flush;
   logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]   perf_stall_cycles;
   logic [31:0]   perf_bubble_cycles;
   logic [31:0]   perf_flush_count;
`endif

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .stall(stall), .flush(flush), .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
      , .perf_stall_cycles(perf_stall_cycles)
      , .perf_bubble_cycles(perf_bubble_cycles)
      , .perf_flush_count(perf_flush_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_data   = 32'd0;
      in_ctrl   = 10'd0;
      out_ready = 1'b0;
      stall     = 1'b0;
      flush     = 1'b0;
      reset     = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
      checks++; if (out_ctrl !== BUB) begin errors++; $display("FAIL reset_out_ctrl: got %0h want %0h", out_ctrl, BUB); end
      checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         in_data = i;
         in_ctrl = 10'h010 + i[9:0];
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %0b want 1", i, in_ready); end
         tick();
         checks++; if (out_valid !== 1'b1 || out_data !== i) begin errors++; $display("FAIL stream_data[%0d]: got v=%0b d=%0h want v=1 d=%0h", i, out_valid, out_data, i); end
         checks++; if (out_ctrl !== 10'h010 + i[9:0]) begin errors++; $display("FAIL stream_ctrl[%0d]: got %0h want %0h", i, out_ctrl, 10'h010 + i[9:0]); end
         checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, occupancy); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== BUB) begin errors++; $display("FAIL stream_drain: got v=%0b occ=%0d ctrl=%0h want v=0 occ=0 ctrl=%0h", out_valid, occupancy, out_ctrl, BUB); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA; in_ctrl = 10'h0A;
      tick();
      checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_a: got occ=%0d rdy=%0b want occ=1 rdy=1", occupancy, in_ready); end
      in_data = 32'hB; in_ctrl = 10'h0B;
      tick();
      checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got occ=%0d rdy=%0b want occ=2 rdy=0", occupancy, in_ready); end
      in_data = 32'hC; in_ctrl = 10'h0C;
      tick();
      checks++; if (occupancy !== 2'd2 || out_data !== 32'hA) begin errors++; $display("FAIL bp_c_held: got occ=%0d d=%0h want occ=2 d=a", occupancy, out_data); end
      out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hA || out_ctrl !== 10'h0A) begin errors++; $display("FAIL bp_pop_a: got v=%0b d=%0h c=%0h want v=1 d=a c=a", out_valid, out_data, out_ctrl); end
      tick();
      checks++; if (out_data !== 32'hB || out_ctrl !== 10'h0B || occupancy !== 2'd1) begin errors++; $display("FAIL bp_pop_b: got d=%0h c=%0h occ=%0d want d=b c=b occ=1", out_data, out_ctrl, occupancy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %0b want 1", in_ready); end
      tick();
      checks++; if (out_data !== 32'hC || out_valid !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_pop_c: got d=%0h v=%0b occ=%0d want d=c v=1 occ=1", out_data, out_valid, occupancy); end
      in_valid = 1'b0;
      tick();
      checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got occ=%0d v=%0b want 0 0", occupancy, out_valid); end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h5A5A; in_ctrl = 10'h3C;
      tick();
      in_data = 32'h7777; in_ctrl = 10'h07;
      stall = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_block: got v=%0b rdy=%0b want 0 0", out_valid, in_ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (occupancy !== 2'd1 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h5A5A) begin errors++; $display("FAIL stall_hold[%0d]: got occ=%0d v=%0b rdy=%0b d=%0h want 1 0 0 5a5a", k, occupancy, out_valid, in_ready, out_data); end
      end
      stall = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h5A5A || out_ctrl !== 10'h3C) begin errors++; $display("FAIL stall_release_x: got v=%0b d=%0h c=%0h want 1 5a5a 3c", out_valid, out_data, out_ctrl); end
      tick();
      checks++; if (out_data !== 32'h7777 || out_valid !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL stall_next: got d=%0h v=%0b occ=%0d want 7777 1 1", out_data, out_valid, occupancy); end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h11; in_ctrl = 10'h011;
      tick();
      in_data = 32'h22; in_ctrl = 10'h022;
      tick();
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_setup: got occ=%0d want 2", occupancy); end
      in_data = 32'h33; in_ctrl = 10'h033;
      stall = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      stall = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== BUB) begin errors++; $display("FAIL flush_clear: got occ=%0d v=%0b c=%0h want 0 0 %0h", occupancy, out_valid, out_ctrl, BUB); end
      out_ready = 1'b1;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_no_ghost: got v=%0b occ=%0d rdy=%0b want 0 0 1", out_valid, occupancy, in_ready); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hDEAD; in_ctrl = 10'h0DE;
      tick();
      in_data = 32'hBEEF; in_ctrl = 10'h0BE;
      tick();
      in_valid = 1'b0;
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL areset_setup: got occ=%0d want 2", occupancy); end
      #1;
      reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== BUB || out_data !== 32'd0) begin errors++; $display("FAIL areset_immediate: got v=%0b occ=%0d c=%0h d=%0h want 0 0 %0h 0", out_valid, occupancy, out_ctrl, out_data, BUB); end
      #1;
      reset = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h4242; in_ctrl = 10'h042;
      tick();
      in_valid = 1'b0;
      checks++; if (occupancy !== 2'd1 || out_data !== 32'h4242) begin errors++; $display("FAIL areset_first_accept: got occ=%0d d=%0h want 1 4242", occupancy, out_data); end
      tick();
   endtask

`ifdef PIPE_STAGE_PERF_EN
   task automatic test_perf();
      do_reset();
      checks++; if (perf_stall_cycles !== 32'd0 || perf_bubble_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d %0d %0d want 0 0 0", perf_stall_cycles, perf_bubble_cycles, perf_flush_count); end
      stall = 1'b1;
      repeat (4) tick();
      stall = 1'b0;
      flush = 1'b1;
      repeat (2) tick();
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      tick();
      checks++; if (perf_stall_cycles !== 32'd4) begin errors++; $display("FAIL perf_stall: got %0d want 4", perf_stall_cycles); end
      checks++; if (perf_bubble_cycles !== 32'd3) begin errors++; $display("FAIL perf_bubble: got %0d want 3", perf_bubble_cycles); end
      checks++; if (perf_flush_count !== 32'd2) begin errors++; $display("FAIL perf_flush: got %0d want 2", perf_flush_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_stall();
      test_flush();
      test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
